// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmit signals of the shared-UART arbiter
//
// Ports (arbiter view, modport slave):
//   ipReqValid [N_REQ]   in   requester i presents a byte
//   ipReqData  [8*N_REQ] in   byte of requester i on [8i+7:8i]
//   ipReqLast  [N_REQ]   in   byte of requester i ends its message
//   opReqReady [N_REQ]   out  owner may transfer this cycle
//   opGrant    [N_REQ]   out  one-hot current owner, 0 when idle
//   opTxData   [8]       out  byte to the UART transmitter
//   opTxSend             out  UART send request
//   ipTxBusy             in   UART transmitter busy
//   opError              out  one-cycle timeout pulse
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   ipReqValid;
  logic [8*N_REQ-1:0] ipReqData;
  logic [N_REQ-1:0]   ipReqLast;
  logic [N_REQ-1:0]   opReqReady;
  logic [N_REQ-1:0]   opGrant;
  logic [7:0]         opTxData;
  logic               opTxSend;
  logic               ipTxBusy;
  logic               opError;

  modport slave (
    input  ipReqValid, ipReqData, ipReqLast, ipTxBusy,
    output opReqReady, opGrant, opTxData, opTxSend, opError
  );

  modport master (
    output ipReqValid, ipReqData, ipReqLast, ipTxBusy,
    input  opReqReady, opGrant, opTxData, opTxSend, opError
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-message arbiter and send sequencer for one UART transmitter
//
// Ports:
//   ipClk    in  system clock
//   ipReset  in  synchronous active-high reset
//   bus      uart_tx_arbiter_if.slave (requester handshake, UART transmit port, error pulse)
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  uart_tx_arbiter_if.slave      bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_IDLE,
    S_WAIT_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              last_q, last_d;
  logic              send_q, send_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  ready;

  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W:0]    search_pos;
  logic [7:0]        sel_data;
  logic              sel_last;
  logic              xfer;
  logic              timed_out;

  // Round-robin search: first valid requester strictly after the pointer, wrapping.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    search_pos = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      search_pos = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (search_pos >= (PTR_W+1)'(N_REQ)) begin
        search_pos = search_pos - (PTR_W+1)'(N_REQ);
      end
      if (!win_found && bus.ipReqValid[search_pos[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = search_pos[PTR_W-1:0];
      end
    end
  end

  // Owner's byte and last flag, selected by the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = sel_data | bus.ipReqData[8*i +: 8];
      end
    end
  end

  assign sel_last  = |(bus.ipReqLast & grant_q);
  assign xfer      = |(bus.ipReqValid & ready);
  assign timed_out = (cnt_q >= CNT_LIM);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    send_d    = send_q;
    error_d   = 1'b0;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    ready     = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          grant_d = N_REQ'(1) << win_idx;
          ptr_d   = win_idx;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        ready = grant_q;
        if (xfer) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          state_d   = S_WAIT_IDLE;
        end else if (timed_out) begin
          // Abandon the stalled owner; pointer stays on it so others go first.
          error_d = 1'b1;
          send_d  = 1'b0;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end

      // A frame lasts thousands of cycles, so waiting here is not bounded.
      S_WAIT_IDLE: begin
        if (!bus.ipTxBusy) begin
          send_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (bus.ipTxBusy) begin
          send_d = 1'b0;
          cnt_d  = '0;
          if (last_q) begin
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          send_d  = 1'b0;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        send_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_INIT;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      send_q    <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      send_q    <= send_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.opReqReady = ready;
  assign bus.opGrant    = grant_q;
  assign bus.opTxData   = tx_data_q;
  assign bus.opTxSend   = send_q;
  assign bus.opError    = error_q;

endmodule
